// File: rtl/zoom_pkg.sv
// Shared constants and helpers for the ZOOM scaler bilinear datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: pipeline depth, internal accumulator width helper, output clamp.
package zoom_pkg;

    // Register stages between input accept and a valid result on pout.
    localparam int LATENCY = 5;

    // Signed accumulator width for one channel. The three guard bits cover
    // the sign plus the worst-case growth of the partial sums before the
    // final cross term pulls the result back into pixel range.
    function automatic int acc_width(input int pix_w, input int frac_w);
        return pix_w + 2 * frac_w + 3;
    endfunction

    // Saturate a signed value into an unsigned pix_w-bit pixel. The value is
    // passed sign-extended to 64 bits so one function serves any lane width;
    // callers keep only the low pix_w bits of the result.
    function automatic logic [31:0] clamp_pix(input logic signed [63:0] v,
                                              input int                 pix_w);
        logic signed [63:0] maxv;
        maxv = (64'sd1 <<< pix_w) - 64'sd1;
        if (v < 64'sd0) begin
            return 32'd0;
        end else if (v > maxv) begin
            return maxv[31:0];
        end else begin
            return v[31:0];
        end
    endfunction

endpackage

// File: rtl/bilerp_pipe_if.sv
// Beat-level bus for the bilinear pipeline: window in, interpolated pixel out.
// Latency: n/a (wiring only).
// Backpressure: in_valid/in_ready on the input side, out_valid/out_ready on the output side.
// master drives beats and out_ready; slave is the pipeline itself.
interface bilerp_pipe_if #(
    parameter int PIX_W  = 5,
    parameter int FRAC_W = 4,
    parameter int CHAN   = 1
);
    logic                    in_valid;
    logic                    in_ready;
    logic [FRAC_W-1:0]       dx;
    logic [FRAC_W-1:0]       dy;
    logic [CHAN*PIX_W-1:0]   pix1;
    logic [CHAN*PIX_W-1:0]   pix2;
    logic [CHAN*PIX_W-1:0]   pix3;
    logic [CHAN*PIX_W-1:0]   pix4;
    logic                    out_valid;
    logic                    out_ready;
    logic [CHAN*PIX_W-1:0]   pout;

    modport master (
        output in_valid, dx, dy, pix1, pix2, pix3, pix4, out_ready,
        input  in_ready, out_valid, pout
    );

    modport slave (
        input  in_valid, dx, dy, pix1, pix2, pix3, pix4, out_ready,
        output in_ready, out_valid, pout
    );
endinterface

// File: rtl/bilerp_lane.sv
// One channel of the bilinear interpolator: five arithmetic register stages.
// Latency: 5 cycles from a load with en=1 to the result on pout.
// Backpressure: every stage holds while en=0; valid tracking lives in the parent.
// Ports: clk, rst_n, en (shared advance), dx/dy phases, pix1..pix4 window, pout result.
module bilerp_lane
    import zoom_pkg::*;
#(
    parameter int PIX_W  = 5,
    parameter int FRAC_W = 4,
    parameter int ROUND  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [FRAC_W-1:0] dx,
    input  logic [FRAC_W-1:0] dy,
    input  logic [PIX_W-1:0]  pix1,
    input  logic [PIX_W-1:0]  pix2,
    input  logic [PIX_W-1:0]  pix3,
    input  logic [PIX_W-1:0]  pix4,
    output logic [PIX_W-1:0]  pout
);
    localparam int W  = acc_width(PIX_W, FRAC_W);
    localparam int F2 = 2 * FRAC_W;

    // Half an output LSB in accumulator units, or nothing when truncating.
    localparam logic signed [W-1:0] RND_C = (ROUND != 0) ? W'(1 << (F2 - 1)) : W'(0);

    function automatic logic signed [W-1:0] ext_pix(input logic [PIX_W-1:0] p);
        return $signed({{(W-PIX_W){1'b0}}, p});
    endfunction

    function automatic logic signed [W-1:0] ext_ph(input logic [FRAC_W-1:0] f);
        return $signed({{(W-FRAC_W){1'b0}}, f});
    endfunction

    // S1: differences against the (1,1) corner, cross sum, phase capture.
    logic signed [W-1:0]  s1_base;
    logic signed [W-1:0]  s1_d21;
    logic signed [W-1:0]  s1_d31;
    logic signed [W-1:0]  s1_crs;
    logic [FRAC_W-1:0]    s1_dx;
    logic [FRAC_W-1:0]    s1_dy;

    always_ff @(posedge clk) begin
        if (en) begin
            s1_base <= ext_pix(pix1) <<< F2;
            s1_d21  <= ext_pix(pix2) - ext_pix(pix1);
            s1_d31  <= ext_pix(pix3) - ext_pix(pix1);
            s1_crs  <= ext_pix(pix4) + ext_pix(pix1) - ext_pix(pix2) - ext_pix(pix3);
            s1_dx   <= dx;
            s1_dy   <= dy;
        end
    end

    // S2: phase product and the two first-order terms, pre-aligned to 2F.
    logic [F2-1:0]        s2_dxdy;
    logic signed [W-1:0]  s2_hx;
    logic signed [W-1:0]  s2_vy;
    logic signed [W-1:0]  s2_base;
    logic signed [W-1:0]  s2_crs;

    always_ff @(posedge clk) begin
        if (en) begin
            s2_dxdy <= {{FRAC_W{1'b0}}, s1_dx} * {{FRAC_W{1'b0}}, s1_dy};
            s2_hx   <= (s1_d21 * ext_ph(s1_dx)) <<< FRAC_W;
            s2_vy   <= (s1_d31 * ext_ph(s1_dy)) <<< FRAC_W;
            s2_base <= s1_base;
            s2_crs  <= s1_crs;
        end
    end

    // S3: second-order cross term alongside the linear partial sum.
    logic signed [W-1:0]  s3_cprod;
    logic signed [W-1:0]  s3_part;

    always_ff @(posedge clk) begin
        if (en) begin
            s3_cprod <= s2_crs * $signed({{(W-F2){1'b0}}, s2_dxdy});
            s3_part  <= s2_base + s2_hx + s2_vy;
        end
    end

    // S4: full accumulator, scaled by 2^(2F).
    logic signed [W-1:0]  s4_acc;

    always_ff @(posedge clk) begin
        if (en) begin
            s4_acc <= s3_part + s3_cprod;
        end
    end

    // S5: round, arithmetic shift back to pixel scale, saturate.
    logic signed [W-1:0]  rnd_acc;
    logic [PIX_W-1:0]     pout_d;

    always_comb begin
        rnd_acc = s4_acc + RND_C;
        pout_d  = PIX_W'(clamp_pix(64'(rnd_acc >>> F2), PIX_W));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pout <= '0;
        end else if (en) begin
            pout <= pout_d;
        end
    end

endmodule

// File: rtl/bilerp_pipe.sv
// Multi-channel bilinear interpolation pipeline between window fetch and output formatter.
// Latency: 5 cycles from accept to out_valid when not stalled; 1 beat/cycle throughput.
// Backpressure: global stall, every stage and the output hold while out_valid & ~out_ready.
// Ports: clk, rst_n (async, active-low), bus (slave side of bilerp_pipe_if).
module bilerp_pipe
    import zoom_pkg::*;
#(
    parameter int PIX_W  = 5,
    parameter int FRAC_W = 4,
    parameter int CHAN   = 1,
    parameter int ROUND  = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    bilerp_pipe_if.slave  bus
);
    logic                  adv;
    logic                  rdy_en_q;
    logic [LATENCY-1:0]    vld_q;
    logic [CHAN*PIX_W-1:0] pout_w;

    // The pipe moves whenever the output slot is empty or being drained.
    assign adv          = ~vld_q[LATENCY-1] | bus.out_ready;

    // rdy_en_q keeps in_ready low for the first cycle out of reset so that a
    // beat presented while the registers were still held is never lost.
    assign bus.in_ready  = adv & rdy_en_q;
    assign bus.out_valid = vld_q[LATENCY-1];
    assign bus.pout      = pout_w;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en_q <= 1'b0;
            vld_q    <= '0;
        end else begin
            rdy_en_q <= 1'b1;
            if (adv) begin
                // Bubbles travel as zeros; nothing is squeezed out.
                vld_q <= {vld_q[LATENCY-2:0], bus.in_valid & rdy_en_q};
            end
        end
    end

    // Lanes share the phases and the advance enable; they never interact.
    for (genvar c = 0; c < CHAN; c++) begin : g_lane
        bilerp_lane #(
            .PIX_W  (PIX_W),
            .FRAC_W (FRAC_W),
            .ROUND  (ROUND)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (adv),
            .dx    (bus.dx),
            .dy    (bus.dy),
            .pix1  (bus.pix1[c*PIX_W +: PIX_W]),
            .pix2  (bus.pix2[c*PIX_W +: PIX_W]),
            .pix3  (bus.pix3[c*PIX_W +: PIX_W]),
            .pix4  (bus.pix4[c*PIX_W +: PIX_W]),
            .pout  (pout_w[c*PIX_W +: PIX_W])
        );
    end

    // A stalled result must not move or change under the consumer.
    property p_stall_hold;
        @(posedge clk) disable iff (!rst_n)
        (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.pout));
    endproperty
    a_stall_hold: assert property (p_stall_hold);

    // Nothing is offered for input while the output is blocked.
    property p_no_accept_in_stall;
        @(posedge clk) disable iff (!rst_n)
        (bus.out_valid && !bus.out_ready) |-> !bus.in_ready;
    endproperty
    a_no_accept_in_stall: assert property (p_no_accept_in_stall);

endmodule

// File: tb/tb_bilerp_pipe.sv
// Directed bench for bilerp_pipe: a CHAN=1/ROUND=1 and a CHAN=3/ROUND=0 instance share stimulus.
// Lane 0 of both instances sees the same window; lanes 1 and 2 see remapped pixels.
module tb_bilerp_pipe;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;
    int   n_out;

    typedef struct {
        int ea;
        int eb0;
        int eb1;
        int eb2;
    } exp_t;

    exp_t q[$];

    bilerp_pipe_if #(.PIX_W(5), .FRAC_W(4), .CHAN(1)) bus_a ();
    bilerp_pipe_if #(.PIX_W(5), .FRAC_W(4), .CHAN(3)) bus_b ();

    bilerp_pipe #(.PIX_W(5), .FRAC_W(4), .CHAN(1), .ROUND(1)) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    bilerp_pipe #(.PIX_W(5), .FRAC_W(4), .CHAN(3), .ROUND(0)) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Reference: weighted sum of the four corners in 1/256 units.
    function automatic int model(input int p1, input int p2, input int p3, input int p4,
                                 input int dx, input int dy, input int rnd);
        int acc;
        int r;
        acc = p1 * (16 - dx) * (16 - dy) + p2 * dx * (16 - dy)
            + p3 * (16 - dx) * dy + p4 * dx * dy;
        if (rnd != 0) acc = acc + 128;
        r = acc >>> 8;
        if (r < 0) r = 0;
        if (r > 31) r = 31;
        return r;
    endfunction

    function automatic int l1(input int p);
        return 31 - p;
    endfunction

    function automatic int l2(input int p);
        return (p * 11 + 7) % 32;
    endfunction

    // p1, p2, p3, p4, dx, dy, expected ROUND=1, expected ROUND=0
    int tv [9][8] = '{
        '{ 7, 31,  0, 19,  0,  0,  7,  7},
        '{10, 20,  0,  0,  8,  0, 15, 15},
        '{ 0, 31, 31,  0,  8,  8, 16, 15},
        '{31, 31, 31, 31, 15, 15, 31, 31},
        '{ 0,  0,  0, 31, 15, 15, 27, 27},
        '{31,  0,  0,  0, 15, 15,  0,  0},
        '{20,  4, 12, 28,  4, 12, 16, 16},
        '{ 3,  9,  5,  0,  5,  3,  5,  4},
        '{ 1,  0,  0,  0,  1,  0,  1,  0}
    };

    task automatic set_out_ready(input logic r);
        bus_a.out_ready = r;
        bus_b.out_ready = r;
    endtask

    // Present one beat and hold it until accepted; queue its expected result.
    task automatic send(input int p1, input int p2, input int p3, input int p4,
                        input int dx, input int dy, input int ea, input int eb0);
        exp_t e;
        bit   ok;
        int   w;
        e.ea  = ea;
        e.eb0 = eb0;
        e.eb1 = model(l1(p1), l1(p2), l1(p3), l1(p4), dx, dy, 0);
        e.eb2 = model(l2(p1), l2(p2), l2(p3), l2(p4), dx, dy, 0);
        bus_a.dx   = 4'(dx);
        bus_a.dy   = 4'(dy);
        bus_a.pix1 = 5'(p1);
        bus_a.pix2 = 5'(p2);
        bus_a.pix3 = 5'(p3);
        bus_a.pix4 = 5'(p4);
        bus_b.dx   = 4'(dx);
        bus_b.dy   = 4'(dy);
        bus_b.pix1 = {5'(l2(p1)), 5'(l1(p1)), 5'(p1)};
        bus_b.pix2 = {5'(l2(p2)), 5'(l1(p2)), 5'(p2)};
        bus_b.pix3 = {5'(l2(p3)), 5'(l1(p3)), 5'(p3)};
        bus_b.pix4 = {5'(l2(p4)), 5'(l1(p4)), 5'(p4)};
        bus_a.in_valid = 1'b1;
        bus_b.in_valid = 1'b1;
        ok = 1'b0;
        w  = 0;
        while (!ok && w < 200) begin
            @(negedge clk);
            ok = bus_a.in_ready;
            if (ok) q.push_back(e);
            @(posedge clk);
            #1;
            w++;
        end
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        if (!ok) chk("accept_timeout", int'(ok), 1);
    endtask

    task automatic check_latency(input string tag);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            seen = bus_a.out_valid;
        end
        chk(tag, n, 5);
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int w;
        w = 0;
        while (q.size() != 0 && w < 500) begin
            @(negedge clk);
            w++;
        end
        chk(tag, q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // Output scoreboard: a transfer happens at the next posedge when both are high.
    always @(negedge clk) begin
        if (rst_n && bus_a.out_valid && bus_a.out_ready) begin
            exp_t e;
            n_out++;
            if (q.size() == 0) begin
                chk("spurious_out", q.size(), 1);
            end else begin
                e = q.pop_front();
                chk("pout_a",    int'(bus_a.pout),       e.ea);
                chk("out_vld_b", int'(bus_b.out_valid),  1);
                chk("pout_b0",   int'(bus_b.pout[4:0]),  e.eb0);
                chk("pout_b1",   int'(bus_b.pout[9:5]),  e.eb1);
                chk("pout_b2",   int'(bus_b.pout[14:10]), e.eb2);
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached with %0d outputs", n_out);
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int held;
        bit drv_done;
        n_chk = 0;
        n_pass = 0;
        n_out = 0;
        rst_n = 1'b0;
        bus_a.in_valid = 1'b0;
        bus_b.in_valid = 1'b0;
        bus_a.dx = '0; bus_a.dy = '0;
        bus_b.dx = '0; bus_b.dy = '0;
        bus_a.pix1 = '0; bus_a.pix2 = '0; bus_a.pix3 = '0; bus_a.pix4 = '0;
        bus_b.pix1 = '0; bus_b.pix2 = '0; bus_b.pix3 = '0; bus_b.pix4 = '0;
        set_out_ready(1'b1);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_out_valid_a", int'(bus_a.out_valid), 0);
        chk("rst_pout_a",      int'(bus_a.pout),      0);
        chk("rst_out_valid_b", int'(bus_b.out_valid), 0);
        chk("rst_pout_b",      int'(bus_b.pout),      0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("in_ready_release", int'(bus_a.in_ready), 0);
        @(negedge clk);
        chk("in_ready_after", int'(bus_a.in_ready), 1);
        @(posedge clk);
        #1;

        // Corner pass-through with fixed latency
        send(tv[0][0], tv[0][1], tv[0][2], tv[0][3], tv[0][4], tv[0][5], tv[0][6], tv[0][7]);
        check_latency("latency_first");
        drain("drain_first");

        // Directed table, back to back
        for (int i = 0; i < 9; i++) begin
            send(tv[i][0], tv[i][1], tv[i][2], tv[i][3], tv[i][4], tv[i][5], tv[i][6], tv[i][7]);
        end
        drain("drain_table");

        // Backpressure: 20 beats streamed, consumer stalls in cycles 8..10
        n0 = n_out;
        held = 0;
        fork
            begin
                for (int i = 1; i <= 20; i++) begin
                    send(i, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31),
                         0, 0, i, i);
                end
            end
            begin
                for (int c = 0; c < 30; c++) begin
                    set_out_ready(!(c >= 8 && c <= 10));
                    @(negedge clk);
                    if (c >= 8 && c <= 10) begin
                        chk("bp_in_ready", int'(bus_a.in_ready), 0);
                        chk("bp_out_valid", int'(bus_a.out_valid), 1);
                        if (c == 8) held = int'(bus_a.pout);
                        else chk("bp_pout_hold", int'(bus_a.pout), held);
                    end
                    @(posedge clk);
                    #1;
                end
                set_out_ready(1'b1);
            end
        join
        drain("drain_bp");
        chk("bp_count", n_out - n0, 20);

        // Random windows with random gaps and random consumer stalls
        drv_done = 1'b0;
        fork
            begin
                for (int k = 0; k < 2000; k++) begin
                    int p1, p2, p3, p4, dx, dy;
                    p1 = $urandom_range(0, 31);
                    p2 = $urandom_range(0, 31);
                    p3 = $urandom_range(0, 31);
                    p4 = $urandom_range(0, 31);
                    dx = $urandom_range(0, 15);
                    dy = $urandom_range(0, 15);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                    send(p1, p2, p3, p4, dx, dy, model(p1, p2, p3, p4, dx, dy, 1),
                         model(p1, p2, p3, p4, dx, dy, 0));
                end
                drv_done = 1'b1;
            end
            begin
                while (!drv_done) begin
                    set_out_ready($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                set_out_ready(1'b1);
            end
        join
        drain("drain_rand");

        // Reset with three beats in flight
        for (int i = 0; i < 3; i++) begin
            send(tv[i + 4][0], tv[i + 4][1], tv[i + 4][2], tv[i + 4][3], tv[i + 4][4],
                 tv[i + 4][5], tv[i + 4][6], tv[i + 4][7]);
        end
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("pre_rst_valid", int'(bus_a.out_valid), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_drop_valid_a", int'(bus_a.out_valid), 0);
        chk("rst_drop_valid_b", int'(bus_b.out_valid), 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_quiet", int'(bus_a.out_valid | bus_b.out_valid), 0);
        end
        @(posedge clk);
        #1;
        send(tv[7][0], tv[7][1], tv[7][2], tv[7][3], tv[7][4], tv[7][5], tv[7][6], tv[7][7]);
        check_latency("latency_post_rst");
        drain("drain_post_rst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
